// File: rtl/instr_encoder_if.sv
// Request and memory-write bus of the instruction encoder.
// The slave modport is the encoder's view; the master modport is the view of whatever drives it.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_op;
  logic [4:0]            in_rs;
  logic [4:0]            in_rt;
  logic [4:0]            in_rd;
  logic [4:0]            in_shamt;
  logic [15:0]           in_imm;
  logic [25:0]           in_target;
  logic                  mem_we;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  err_illegal;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err_illegal
  );
endinterface

// File: rtl/instr_encoder.sv
// Mnemonic-to-MIPS instruction encoder and sequential program loader.
// Encoded words pass through a 2-entry FIFO so request acceptance is decoupled from memory backpressure.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  instr_encoder_if.slave bus
);

  typedef enum logic [4:0] {
    OpAdd  = 5'd0,  OpAddu = 5'd1,  OpSub  = 5'd2,  OpSubu = 5'd3,  OpAnd   = 5'd4,
    OpOr   = 5'd5,  OpXor  = 5'd6,  OpNor  = 5'd7,  OpSlt  = 5'd8,  OpSltu  = 5'd9,
    OpSll  = 5'd10, OpSrl  = 5'd11, OpSra  = 5'd12, OpJr   = 5'd13, OpJalr  = 5'd14,
    OpLw   = 5'd15, OpSw   = 5'd16, OpLui  = 5'd17, OpAddi = 5'd18, OpAddiu = 5'd19,
    OpAndi = 5'd20, OpSlti = 5'd21, OpSltiu = 5'd22, OpBeq = 5'd23, OpJ     = 5'd24,
    OpJal  = 5'd25
  } mnemonic_e;

  typedef enum logic [2:0] {
    FmtR, FmtShift, FmtJr, FmtJalr, FmtI, FmtLui, FmtJ, FmtIllegal
  } format_e;

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH+1:0] CapLimit = {1'b0, 1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CountMax = {1'b1, {ADDR_WIDTH{1'b0}}};

  format_e                fmt;
  logic [5:0]             code;
  logic [31:0]            encWord;
  logic                   encLegal;
  logic [31:0]            fifoMem [2];
  logic                   wrPtr, rdPtr;
  logic [1:0]             fifoCnt;
  logic [ADDR_WIDTH-1:0]  addrQ;
  logic [ADDR_WIDTH:0]    countQ;
  logic                   errQ;
  logic [ADDR_WIDTH+1:0]  pending;
  logic                   accept, push, pop;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fmt  = FmtIllegal;
    code = 6'h00;
    unique case (bus.in_op)
      OpAdd:   begin fmt = FmtR;     code = 6'h20; end
      OpAddu:  begin fmt = FmtR;     code = 6'h21; end
      OpSub:   begin fmt = FmtR;     code = 6'h22; end
      OpSubu:  begin fmt = FmtR;     code = 6'h23; end
      OpAnd:   begin fmt = FmtR;     code = 6'h24; end
      OpOr:    begin fmt = FmtR;     code = 6'h25; end
      OpXor:   begin fmt = FmtR;     code = 6'h26; end
      OpNor:   begin fmt = FmtR;     code = 6'h27; end
      OpSlt:   begin fmt = FmtR;     code = 6'h2a; end
      OpSltu:  begin fmt = FmtR;     code = 6'h2b; end
      OpSll:   begin fmt = FmtShift; code = 6'h00; end
      OpSrl:   begin fmt = FmtShift; code = 6'h02; end
      OpSra:   begin fmt = FmtShift; code = 6'h03; end
      OpJr:    begin fmt = FmtJr;    code = 6'h08; end
      OpJalr:  begin fmt = FmtJalr;  code = 6'h09; end
      OpLw:    begin fmt = FmtI;     code = 6'h23; end
      OpSw:    begin fmt = FmtI;     code = 6'h2b; end
      OpLui:   begin fmt = FmtLui;   code = 6'h0f; end
      OpAddi:  begin fmt = FmtI;     code = 6'h08; end
      OpAddiu: begin fmt = FmtI;     code = 6'h09; end
      OpAndi:  begin fmt = FmtI;     code = 6'h0c; end
      OpSlti:  begin fmt = FmtI;     code = 6'h0a; end
      OpSltiu: begin fmt = FmtI;     code = 6'h0b; end
      OpBeq:   begin fmt = FmtI;     code = 6'h04; end
      OpJ:     begin fmt = FmtJ;     code = 6'h02; end
      OpJal:   begin fmt = FmtJ;     code = 6'h03; end
      default: begin fmt = FmtIllegal; code = 6'h00; end
    endcase
  end

  // Fields a format does not use are packed as zeros.
  always_comb begin
    encLegal = 1'b1;
    encWord  = '0;
    case (fmt)
      FmtR:     encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, code};
      FmtShift: encWord = {6'h00, 5'd0, bus.in_rt, bus.in_rd, bus.in_shamt, code};
      FmtJr:    encWord = {6'h00, bus.in_rs, 15'd0, code};
      FmtJalr:  encWord = {6'h00, bus.in_rs, 5'd0, bus.in_rd, 5'd0, code};
      FmtI:     encWord = {code, bus.in_rs, bus.in_rt, bus.in_imm};
      FmtLui:   encWord = {code, 5'd0, bus.in_rt, bus.in_imm};
      FmtJ:     encWord = {code, bus.in_target};
      default:  encLegal = 1'b0;
    endcase
  end

  // Words already queued count against capacity so the loader never overruns memory.
  assign pending      = (ADDR_WIDTH+2)'(countQ) + (ADDR_WIDTH+2)'(fifoCnt);
  assign bus.in_ready = reset && !flush && (fifoCnt < 2'd2) && (pending < CapLimit);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && encLegal;
  assign pop          = (fifoCnt != 2'd0) && bus.mem_ready;

  assign bus.mem_we      = (fifoCnt != 2'd0);
  assign bus.mem_wdata   = bus.mem_we ? fifoMem[rdPtr] : 32'h0;
  assign bus.mem_addr    = addrQ;
  assign bus.count       = countQ;
  assign bus.full        = (countQ == CountMax);
  assign bus.err_illegal = errQ;

  // NOTE: the FIFO storage is not reset; fifoCnt gates every read of it, so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= encWord;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      fifoCnt <= 2'd0;
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      addrQ   <= BaseAddr;
      countQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      if (push) wrPtr <= ~wrPtr;
      if (pop) begin
        rdPtr  <= ~rdPtr;
        addrQ  <= addrQ + ADDR_WIDTH'(1);
        countQ <= countQ + (ADDR_WIDTH+1)'(1);
      end
      if (accept && !encLegal) errQ <= 1'b1;
      fifoCnt <= fifoCnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder: an 8-bit instance for encoding, ordering and
// backpressure, and a 2-bit instance for the capacity limit and flush.
module tb_instr_encoder;

  localparam int AW  = 8;
  localparam int SAW = 2;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic flush  = 1'b0;
  logic sflush = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_WIDTH(AW))  bus ();
  instr_encoder_if #(.ADDR_WIDTH(SAW)) sbus ();

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );
  instr_encoder #(.ADDR_WIDTH(SAW), .BASE_ADDR(0)) sdut (
    .clk(clk), .reset(reset), .flush(sflush), .bus(sbus)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   nPushed     = 0;

  localparam logic [5:0] FUNCT [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                         6'h27, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
  localparam logic [5:0] OPC [15:23]  = '{6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a,
                                         6'h0b, 6'h04};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding: bit 32 is the legal flag, bits 31:0 the word.
  function automatic logic [32:0] model(input logic [4:0] op, rs, rt, rd, sh,
                                        input logic [15:0] imm, input logic [25:0] tgt);
    logic [4:0] xs, xt, xd, xsh;
    if (op <= 5'd14) begin
      xs = rs; xt = rt; xd = rd; xsh = 5'd0;
      if (op >= 5'd10 && op <= 5'd12) begin xs = 5'd0; xsh = sh; end
      if (op == 5'd13) begin xt = 5'd0; xd = 5'd0; end
      if (op == 5'd14) xt = 5'd0;
      return {1'b1, 6'h00, xs, xt, xd, xsh, FUNCT[op]};
    end else if (op <= 5'd23) begin
      xs = (op == 5'd17) ? 5'd0 : rs;
      return {1'b1, OPC[op], xs, rt, imm};
    end else if (op <= 5'd25) begin
      return {1'b1, (op == 5'd24) ? 6'h02 : 6'h03, tgt};
    end
    return {1'b0, 32'h0};
  endfunction

  task automatic drive(input logic [4:0] op, rs, rt, rd, sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    bus.in_op = op; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt;
    bus.in_valid = 1'b1;
  endtask

  // Holds the request until accepted; the expected word enters the scoreboard at acceptance.
  task automatic wait_accept(input string tag);
    logic        got;
    logic [32:0] r;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        r = model(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_imm,
                  bus.in_target);
        if (r[32]) begin
          sb.push_back({8'(nPushed), r[31:0]});
          nPushed++;
        end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) check({tag, "_accept_timeout"}, 64'(got), 64'd1);
  endtask

  // Issue into an idle pipe with mem_ready high; the word shows up on the very next cycle.
  task automatic req_check(input string tag, input logic [4:0] op, rs, rt, rd, sh,
                           input logic [15:0] imm, input logic [25:0] tgt,
                           input logic [31:0] expWord);
    drive(op, rs, rt, rd, sh, imm, tgt);
    wait_accept(tag);
    @(negedge clk);
    check({tag, "_we"}, 64'(bus.mem_we), 64'd1);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(expWord));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (reset && bus.mem_we && bus.mem_ready) begin
      check("sb_nonempty_on_write", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] holdData;
    logic [7:0]  holdAddr;
    logic [8:0]  holdCount;
    int          acc;

    bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
    drive(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0);
    sbus.in_valid = 1'b0; sbus.mem_ready = 1'b0;
    sbus.in_op = 5'd18; sbus.in_rs = 5'd0; sbus.in_rt = 5'd1; sbus.in_rd = 5'd0;
    sbus.in_shamt = 5'd0; sbus.in_imm = 16'h0001; sbus.in_target = 26'd0;

    // Reset state, with a valid request held to show it is refused.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_err", 64'(bus.err_illegal), 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.mem_ready = 1'b1;

    // First word: one-cycle latency, address 0, count 1 after the write.
    drive(5'd18, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0);
    wait_accept("addi");
    @(negedge clk);
    check("addi_we", 64'(bus.mem_we), 64'd1);
    check("addi_addr", 64'(bus.mem_addr), 64'd0);
    check("addi_wdata", 64'(bus.mem_wdata), 64'h20080005);
    @(posedge clk); #1;
    @(negedge clk);
    check("addi_count", 64'(bus.count), 64'd1);
    check("addi_we_after", 64'(bus.mem_we), 64'd0);
    @(posedge clk); #1;

    req_check("add", 5'd0, 5'd8, 5'd9, 5'd10, 5'd7, 16'hffff, 26'h3ffffff, 32'h01095020);
    req_check("sll", 5'd10, 5'd3, 5'd9, 5'd8, 5'd2, 16'h0, 26'h0, 32'h00094080);
    req_check("lui", 5'd17, 5'd5, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3C081234);
    req_check("j", 5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h08100000);

    // Every legal mnemonic with random fields, streamed back to back.
    for (int op = 0; op <= 25; op++) begin
      drive(5'(op), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom));
      wait_accept("stream");
    end
    drain("stream");
    check("count_stream", 64'(bus.count), 64'(nPushed));

    // Backpressure: two words fill the FIFO, the third waits, the head stays put.
    bus.mem_ready = 1'b0;
    drive(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    wait_accept("bp_a");
    drive(5'd19, 5'd4, 5'd5, 5'd0, 5'd0, 16'h8001, 26'h0);
    wait_accept("bp_b");
    drive(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2abcdef);
    @(negedge clk);
    check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    holdData = bus.mem_wdata;
    holdAddr = bus.mem_addr;
    check("bp_head", 64'(holdData), 64'(sb[0].data));
    repeat (2) @(negedge clk);
    check("bp_hold_we", 64'(bus.mem_we), 64'd1);
    check("bp_hold_data", 64'(bus.mem_wdata), 64'(holdData));
    check("bp_hold_addr", 64'(bus.mem_addr), 64'(holdAddr));
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    wait_accept("bp_c");
    drain("bp");
    check("count_bp", 64'(bus.count), 64'(nPushed));

    // Illegal op: sticky error, nothing written, address unchanged.
    holdAddr  = bus.mem_addr;
    holdCount = bus.count;
    drive(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
    wait_accept("illegal31");
    @(negedge clk);
    check("ill_err", 64'(bus.err_illegal), 64'd1);
    check("ill_we", 64'(bus.mem_we), 64'd0);
    check("ill_addr", 64'(bus.mem_addr), 64'(holdAddr));
    repeat (2) @(negedge clk);
    check("ill_err_sticky", 64'(bus.err_illegal), 64'd1);
    check("ill_count", 64'(bus.count), 64'(holdCount));
    @(posedge clk); #1;

    // Reset while two words are queued discards them.
    bus.mem_ready = 1'b0;
    drive(5'd15, 5'd2, 5'd3, 5'd0, 5'd0, 16'h10, 26'h0);
    wait_accept("rq_a");
    drive(5'd16, 5'd2, 5'd3, 5'd0, 5'd0, 16'h14, 26'h0);
    wait_accept("rq_b");
    @(negedge clk);
    check("rq_we_before", 64'(bus.mem_we), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    nPushed = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rq_we", 64'(bus.mem_we), 64'd0);
    check("rq_count", 64'(bus.count), 64'd0);
    check("rq_addr", 64'(bus.mem_addr), 64'd0);
    check("rq_err", 64'(bus.err_illegal), 64'd0);
    check("rq_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    drive(5'd23, 5'd4, 5'd5, 5'd0, 5'd0, 16'hfffe, 26'h0);
    wait_accept("rq_after");
    drain("rq");

    // Capacity limit on the 4-word instance, then flush.
    sbus.mem_ready = 1'b1;
    sbus.in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 40 && acc < 4; i++) begin
      @(negedge clk);
      if (sbus.in_ready) acc++;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("cap_accepted", 64'(acc), 64'd4);
    check("cap_full", 64'(sbus.full), 64'd1);
    check("cap_in_ready", 64'(sbus.in_ready), 64'd0);
    check("cap_count", 64'(sbus.count), 64'd4);
    check("cap_addr_wrap", 64'(sbus.mem_addr), 64'd0);
    check("cap_we", 64'(sbus.mem_we), 64'd0);
    @(posedge clk); #1;
    sflush = 1'b1;
    @(negedge clk);
    check("sflush_in_ready", 64'(sbus.in_ready), 64'd0);
    @(posedge clk); #1;
    sflush = 1'b0;
    sbus.in_valid = 1'b0;
    @(negedge clk);
    check("sflush_count", 64'(sbus.count), 64'd0);
    check("sflush_addr", 64'(sbus.mem_addr), 64'd0);
    check("sflush_full", 64'(sbus.full), 64'd0);
    check("sflush_in_ready", 64'(sbus.in_ready), 64'd1);
    @(posedge clk); #1;

    // First illegal code, then flush clears the sticky error and the write pointer.
    drive(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    wait_accept("illegal26");
    @(negedge clk);
    check("ill26_err", 64'(bus.err_illegal), 64'd1);
    check("ill26_we", 64'(bus.mem_we), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    nPushed = 0;
    @(negedge clk);
    check("flush_err", 64'(bus.err_illegal), 64'd0);
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_addr", 64'(bus.mem_addr), 64'd0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
